// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: ball/paddle motion, collisions, scoring and the
// serve/point/game-over sequence, all advanced once per frame_tick.
module pong_game_ctrl #(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PAD_H        = 64,
    parameter int unsigned PAD_W        = 8,
    parameter int unsigned PAD_L_X      = 16,
    parameter int unsigned PAD_R_X      = 616,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned PAD_SPEED    = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       btn_up_l,
    input  logic       btn_dn_l,
    input  logic       btn_up_r,
    input  logic       btn_dn_r,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] pad_l_y,
    output logic [9:0] pad_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] game_state,
    output logic       game_over
);

    localparam int unsigned PW         = 10;
    localparam int unsigned SW         = 12;
    localparam int unsigned SCW        = 4;
    localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CW         = $clog2(MAX_FRAMES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [PW-1:0] BALL_X0  = PW'((H_RES - BALL_SIZE) / 2);
    localparam logic [PW-1:0] BALL_Y0  = PW'((V_RES - BALL_SIZE) / 2);
    localparam logic [PW-1:0] PAD_Y0   = PW'((V_RES - PAD_H) / 2);
    localparam logic [PW-1:0] PAD_MAX  = PW'(V_RES - PAD_H);
    localparam logic [PW-1:0] PAD_STEP = PW'(PAD_SPEED);
    localparam logic [PW-1:0] X_HIT_L  = PW'(PAD_L_X + PAD_W);
    localparam logic [PW-1:0] X_HIT_R  = PW'(PAD_R_X - BALL_SIZE);
    localparam logic [PW-1:0] Y_BOT    = PW'(V_RES - BALL_SIZE);

    localparam logic signed [SW-1:0] ZERO_S   = '0;
    localparam logic signed [SW-1:0] STEP_S   = SW'(BALL_SPEED);
    localparam logic signed [SW-1:0] X_MAX_S  = SW'(H_RES - BALL_SIZE);
    localparam logic signed [SW-1:0] Y_MAX_S  = SW'(V_RES - BALL_SIZE);
    localparam logic signed [SW-1:0] BS_S     = SW'(BALL_SIZE);
    localparam logic signed [SW-1:0] PH_S     = SW'(PAD_H);
    localparam logic signed [SW-1:0] L_X_S    = SW'(PAD_L_X);
    localparam logic signed [SW-1:0] L_EDGE_S = SW'(PAD_L_X + PAD_W);
    localparam logic signed [SW-1:0] R_X_S    = SW'(PAD_R_X);
    localparam logic signed [SW-1:0] R_EDGE_S = SW'(PAD_R_X + PAD_W);

    localparam logic [SCW-1:0] WIN        = SCW'(WIN_SCORE);
    localparam logic [CW-1:0]  SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0]  POINT_LAST = CW'(POINT_FRAMES - 1);

    logic [2:0]     state, state_nxt;
    logic [PW-1:0]  ball_x_nxt, ball_y_nxt, pad_l_nxt, pad_r_nxt;
    logic [SCW-1:0] score_l_nxt, score_r_nxt;
    logic           game_over_nxt;
    logic           dx_neg, dx_neg_nxt, dy_neg, dy_neg_nxt;
    logic [CW-1:0]  frame_cnt, frame_cnt_nxt;

    logic signed [SW-1:0] bx_s, by_s, pl_s, pr_s, nx, ny;
    logic                 hit_l, hit_r, miss_l, miss_r, y_top, y_bot;
    logic [SCW-1:0]       score_l_inc, score_r_inc;
    logic [PW-1:0]        pad_l_mv, pad_r_mv;

    // Paddle step with clamping; both or neither button holds position.
    function automatic logic [PW-1:0] pad_step(input logic [PW-1:0] y,
                                               input logic up, input logic dn);
        logic [PW-1:0] r;
        r = y;
        if (up && !dn) begin
            r = (y < PAD_STEP) ? '0 : y - PAD_STEP;
        end else if (dn && !up) begin
            r = (y > PAD_MAX - PAD_STEP) ? PAD_MAX : y + PAD_STEP;
        end
        return r;
    endfunction

    // Signed next-position math avoids 10-bit wrap at the screen edges.
    assign bx_s = $signed(SW'(ball_x));
    assign by_s = $signed(SW'(ball_y));
    assign pl_s = $signed(SW'(pad_l_y));
    assign pr_s = $signed(SW'(pad_r_y));
    assign nx   = bx_s + (dx_neg ? -STEP_S : STEP_S);
    assign ny   = by_s + (dy_neg ? -STEP_S : STEP_S);

    assign y_top  = (ny <= ZERO_S);
    assign y_bot  = (ny >= Y_MAX_S);
    assign hit_l  = dx_neg && (nx <= L_EDGE_S) && (nx + BS_S > L_X_S)
                    && (ny + BS_S > pl_s) && (ny < pl_s + PH_S);
    assign hit_r  = !dx_neg && (nx + BS_S >= R_X_S) && (nx < R_EDGE_S)
                    && (ny + BS_S > pr_s) && (ny < pr_s + PH_S);
    assign miss_l = (nx <= ZERO_S) && !hit_l;
    assign miss_r = (nx >= X_MAX_S) && !hit_r;

    assign score_l_inc = (score_l < WIN) ? score_l + SCW'(1) : score_l;
    assign score_r_inc = (score_r < WIN) ? score_r + SCW'(1) : score_r;
    assign pad_l_mv    = pad_step(pad_l_y, btn_up_l, btn_dn_l);
    assign pad_r_mv    = pad_step(pad_r_y, btn_up_r, btn_dn_r);

    assign game_state = state;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        ball_x_nxt    = ball_x;
        ball_y_nxt    = ball_y;
        pad_l_nxt     = pad_l_y;
        pad_r_nxt     = pad_r_y;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        dx_neg_nxt    = dx_neg;
        dy_neg_nxt    = dy_neg;
        frame_cnt_nxt = frame_cnt;

        if (start && (state == ST_IDLE || state == ST_OVER)) begin
            score_l_nxt   = '0;
            score_r_nxt   = '0;
            ball_x_nxt    = BALL_X0;
            ball_y_nxt    = BALL_Y0;
            frame_cnt_nxt = '0;
            state_nxt     = ST_SERVE;
        end else if (frame_tick) begin
            case (state)
                ST_SERVE: begin
                    pad_l_nxt = pad_l_mv;
                    pad_r_nxt = pad_r_mv;
                    if (frame_cnt == SERVE_LAST) begin
                        frame_cnt_nxt = '0;
                        state_nxt     = ST_PLAY;
                    end else begin
                        frame_cnt_nxt = frame_cnt + CW'(1);
                    end
                end
                ST_PLAY: begin
                    pad_l_nxt = pad_l_mv;
                    pad_r_nxt = pad_r_mv;
                    if (miss_l) begin
                        // Ball freezes; next serve heads toward the loser.
                        score_r_nxt   = score_r_inc;
                        dx_neg_nxt    = 1'b1;
                        frame_cnt_nxt = '0;
                        state_nxt     = (score_r_inc == WIN) ? ST_OVER : ST_POINT;
                    end else if (miss_r) begin
                        score_l_nxt   = score_l_inc;
                        dx_neg_nxt    = 1'b0;
                        frame_cnt_nxt = '0;
                        state_nxt     = (score_l_inc == WIN) ? ST_OVER : ST_POINT;
                    end else begin
                        ball_y_nxt = y_top ? '0 : (y_bot ? Y_BOT : ny[PW-1:0]);
                        dy_neg_nxt = y_top ? 1'b0 : (y_bot ? 1'b1 : dy_neg);
                        ball_x_nxt = hit_l ? X_HIT_L : (hit_r ? X_HIT_R : nx[PW-1:0]);
                        dx_neg_nxt = hit_l ? 1'b0 : (hit_r ? 1'b1 : dx_neg);
                    end
                end
                ST_POINT: begin
                    pad_l_nxt = pad_l_mv;
                    pad_r_nxt = pad_r_mv;
                    if (frame_cnt == POINT_LAST) begin
                        frame_cnt_nxt = '0;
                        ball_x_nxt    = BALL_X0;
                        ball_y_nxt    = BALL_Y0;
                        state_nxt     = ST_SERVE;
                    end else begin
                        frame_cnt_nxt = frame_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end

        game_over_nxt = (state_nxt == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            pad_l_y   <= PAD_Y0;
            pad_r_y   <= PAD_Y0;
            score_l   <= '0;
            score_r   <= '0;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            frame_cnt <= '0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            ball_x    <= ball_x_nxt;
            ball_y    <= ball_y_nxt;
            pad_l_y   <= pad_l_nxt;
            pad_r_y   <= pad_r_nxt;
            score_l   <= score_l_nxt;
            score_r   <= score_r_nxt;
            dx_neg    <= dx_neg_nxt;
            dy_neg    <= dy_neg_nxt;
            frame_cnt <= frame_cnt_nxt;
            game_over <= game_over_nxt;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a behavioural game model feeds a per-cycle
// scoreboard, plus directed checks at the interesting game events.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start;
    logic       btn_up_l, btn_dn_l, btn_up_r, btn_dn_r;
    logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic [3:0] score_l, score_r;
    logic [2:0] game_state;
    logic       game_over;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .btn_up_l   (btn_up_l),
        .btn_dn_l   (btn_dn_l),
        .btn_up_r   (btn_up_r),
        .btn_dn_r   (btn_dn_r),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .pad_l_y    (pad_l_y),
        .pad_r_y    (pad_r_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_state (game_state),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] pl;
        logic [9:0] pr;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Game model state
    int m_state, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_cnt, m_over;
    bit ev_hit_l, ev_hit_r, ev_miss_l, ev_miss_r, ev_top, ev_bot;
    bit t_hit_l, t_hit_r, t_miss_l, t_top, t_bot;
    bit ul, dl, ur, dr;

    function automatic int pmove(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    task automatic model_step(input bit tk, input bit st, input bit rst,
                              input bit u_l, input bit d_l, input bit u_r, input bit d_r);
        int nx, ny, npl, npr;
        bit hl, hr;
        {ev_hit_l, ev_hit_r, ev_miss_l, ev_miss_r, ev_top, ev_bot} = '0;
        if (rst) begin
            m_state = 0; m_bx = 316; m_by = 236; m_dx = 2; m_dy = 2;
            m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_cnt = 0; m_over = 0;
            return;
        end
        if (st && (m_state == 0 || m_state == 4)) begin
            m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_cnt = 0;
            m_state = 1; m_over = 0;
            return;
        end
        if (!tk || m_state == 0 || m_state == 4) return;
        npl = pmove(m_pl, u_l, d_l);
        npr = pmove(m_pr, u_r, d_r);
        if (m_state == 1) begin
            if (m_cnt == 59) begin m_cnt = 0; m_state = 2; end
            else m_cnt++;
        end else if (m_state == 3) begin
            if (m_cnt == 89) begin m_cnt = 0; m_state = 1; m_bx = 316; m_by = 236; end
            else m_cnt++;
        end else begin
            nx = m_bx + m_dx;
            ny = m_by + m_dy;
            hl = (m_dx < 0) && (nx <= 24) && (nx + 8 > 16) && (ny + 8 > m_pl) && (ny < m_pl + 64);
            hr = (m_dx > 0) && (nx + 8 >= 616) && (nx < 624) && (ny + 8 > m_pr) && (ny < m_pr + 64);
            if (nx <= 0 && !hl) begin
                ev_miss_l = 1;
                if (m_sr < 9) m_sr++;
                m_dx = -2; m_cnt = 0;
                m_state = (m_sr == 9) ? 4 : 3;
            end else if (nx >= 632 && !hr) begin
                ev_miss_r = 1;
                if (m_sl < 9) m_sl++;
                m_dx = 2; m_cnt = 0;
                m_state = (m_sl == 9) ? 4 : 3;
            end else begin
                if (ny <= 0) begin m_by = 0; m_dy = 2; ev_top = 1; end
                else if (ny >= 472) begin m_by = 472; m_dy = -2; ev_bot = 1; end
                else m_by = ny;
                if (hl) begin m_bx = 24; m_dx = 2; ev_hit_l = 1; end
                else if (hr) begin m_bx = 608; m_dx = -2; ev_hit_r = 1; end
                else m_bx = nx;
            end
        end
        m_pl = npl;
        m_pr = npr;
        m_over = (m_state == 4) ? 1 : 0;
    endtask

    function automatic snap_t model_snap();
        return '{st: 3'(m_state), bx: 10'(m_bx), by: 10'(m_by), pl: 10'(m_pl),
                 pr: 10'(m_pr), sl: 4'(m_sl), sr: 4'(m_sr), go: 1'(m_over)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one clock; the expected snapshot is queued at drive time, popped after the edge.
    task automatic cycle(input bit tk, input bit st, input bit rst,
                         input bit u_l, input bit d_l, input bit u_r, input bit d_r);
        snap_t got, exp;
        frame_tick = tk; start = st; reset = rst;
        btn_up_l = u_l; btn_dn_l = d_l; btn_up_r = u_r; btn_dn_r = d_r;
        model_step(tk, st, rst, u_l, d_l, u_r, d_r);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        frame_tick = 1'b0; start = 1'b0; reset = 1'b0;
        got = '{st: game_state, bx: ball_x, by: ball_y, pl: pad_l_y, pr: pad_r_y,
                sl: score_l, sr: score_r, go: game_over};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL scoreboard tk=%0b st=%0b rst=%0b observed=%h expected=%h",
                   tk, st, rst, got, exp);
        end
    endtask

    task automatic tick(input bit u_l, input bit d_l, input bit u_r, input bit d_r);
        cycle(1'b1, 1'b0, 1'b0, u_l, d_l, u_r, d_r);
        t_hit_l = ev_hit_l; t_hit_r = ev_hit_r; t_miss_l = ev_miss_l;
        t_top = ev_top; t_bot = ev_bot;
        cycle(1'b0, 1'b0, 1'b0, u_l, d_l, u_r, d_r);
    endtask

    // mode 0: idle, 1: track the ball, 2: keep away from the ball
    task automatic steer(input int y, input int mode, output bit up, output bit dn);
        int tgt;
        up = 1'b0; dn = 1'b0;
        if (mode == 0) return;
        tgt = (mode == 1) ? m_by - 28 : ((m_by < 236) ? 416 : 0);
        if (y < tgt - 2) dn = 1'b1;
        else if (y > tgt + 2) up = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(game_state), 0);
        chk({tag, "_bx"}, 32'(ball_x), 316);
        chk({tag, "_by"}, 32'(ball_y), 236);
        chk({tag, "_pl"}, 32'(pad_l_y), 208);
        chk({tag, "_pr"}, 32'(pad_r_y), 208);
        chk({tag, "_sl"}, 32'(score_l), 0);
        chk({tag, "_sr"}, 32'(score_r), 0);
        chk({tag, "_go"}, 32'(game_over), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre_bx, pre_by, keep_pl, keep_pr;
        bit found, seen_bot, seen_top, seen_hr, pend_bot;
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        {btn_up_l, btn_dn_l, btn_up_r, btn_dn_r} = '0;

        // Reset and idle behaviour
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_reset_vals("reset");
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("idle_frozen_pl", 32'(pad_l_y), 208);
        chk("idle_frozen_state", 32'(game_state), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_to_serve", 32'(game_state), 1);

        // Serve hold with paddle clamps, then launch
        for (int i = 1; i <= 59; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            chk("serve_state", 32'(game_state), 1);
            chk("serve_bx", 32'(ball_x), 316);
            chk("serve_by", 32'(ball_y), 236);
        end
        chk("clamp_pl_top", 32'(pad_l_y), 0);
        chk("clamp_pr_bot", 32'(pad_r_y), 416);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk("both_btn_pl", 32'(pad_l_y), 0);
        chk("both_btn_pr", 32'(pad_r_y), 416);
        chk("launch_state", 32'(game_state), 2);
        chk("launch_bx", 32'(ball_x), 316);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_step_bx", 32'(ball_x), 318);
        chk("first_step_by", 32'(ball_y), 238);

        // Rally with both paddles tracking until a left paddle return
        found = 0; seen_bot = 0; seen_top = 0; seen_hr = 0; pend_bot = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            steer(m_pl, 1, ul, dl);
            steer(m_pr, 1, ur, dr);
            tick(ul, dl, ur, dr);
            if (pend_bot) begin
                chk("wall_bot_next_y", 32'(ball_y), 470);
                pend_bot = 0;
            end
            if (t_bot && !seen_bot) begin
                chk("wall_bot_y", 32'(ball_y), 472);
                seen_bot = 1; pend_bot = 1;
            end
            if (t_top && !seen_top) begin
                chk("wall_top_y", 32'(ball_y), 0);
                seen_top = 1;
            end
            if (t_hit_r && !seen_hr) begin
                chk("right_hit_x", 32'(ball_x), 608);
                seen_hr = 1;
            end
            if (t_hit_l) begin
                found = 1;
                chk("left_hit_x", 32'(ball_x), 24);
                chk("left_hit_sl", 32'(score_l), 0);
                chk("left_hit_sr", 32'(score_r), 0);
            end
        end
        chk("left_hit_seen", 32'(found), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_left_hit_x", 32'(ball_x), 26);

        // Left paddle dodges: left miss
        found = 0; pre_bx = 0; pre_by = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            steer(m_pl, 2, ul, dl);
            steer(m_pr, 1, ur, dr);
            pre_bx = m_bx; pre_by = m_by;
            tick(ul, dl, ur, dr);
            if (t_miss_l) found = 1;
        end
        chk("left_miss_seen", 32'(found), 1);
        chk("left_miss_sr", 32'(score_r), 1);
        chk("left_miss_sl", 32'(score_l), 0);
        chk("left_miss_state", 32'(game_state), 3);
        chk("left_miss_frozen_x", 32'(ball_x), 32'(pre_bx));
        chk("left_miss_frozen_y", 32'(ball_y), 32'(pre_by));
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("point_state", 32'(game_state), 3);
        chk("point_frozen_x", 32'(ball_x), 32'(pre_bx));

        // Right paddle dodges until the left player wins
        found = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            steer(m_pl, 1, ul, dl);
            steer(m_pr, 2, ur, dr);
            tick(ul, dl, ur, dr);
            if (m_state == 4) found = 1;
        end
        chk("game_over_seen", 32'(found), 1);
        chk("over_sl", 32'(score_l), 9);
        chk("over_sr", 32'(score_r), 1);
        chk("over_state", 32'(game_state), 4);
        chk("over_flag", 32'(game_over), 1);

        // Frozen in OVER, then start coincident with a tick
        keep_pl = m_pl; keep_pr = m_pr;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("over_frozen_state", 32'(game_state), 4);
        chk("over_frozen_pl", 32'(pad_l_y), 32'(keep_pl));
        chk("over_frozen_sl", 32'(score_l), 9);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("restart_state", 32'(game_state), 1);
        chk("restart_sl", 32'(score_l), 0);
        chk("restart_sr", 32'(score_r), 0);
        chk("restart_bx", 32'(ball_x), 316);
        chk("restart_by", 32'(ball_y), 236);
        chk("restart_go", 32'(game_over), 0);
        chk("restart_pl_still", 32'(pad_l_y), 32'(keep_pl));
        chk("restart_pr_still", 32'(pad_r_y), 32'(keep_pr));

        // Start ignored during PLAY, then reset mid-frame
        for (int i = 0; i < 65; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("replay_state", 32'(game_state), 2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_ignored", 32'(game_state), 2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_tick_ignored", 32'(game_state), 2);
        chk("start_tick_sl", 32'(score_l), 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_reset_vals("midreset");
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("post_reset_idle", 32'(game_state), 0);
        chk("post_reset_pl", 32'(pad_l_y), 208);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
